gvp_stream_packer: RTL and testbench
====================================

GVP_STREAM_PACKER -- requirements
Module: gvp_stream_packer

Interface
REQ-001 SHALL have parameter NUM_CH, default 16, meaning number of packable 32-bit channels.
REQ-002 SHALL have parameter TRAILER_WORD, default 32'hEEEEEEEE, meaning the end-of-program mark word.
REQ-003 SHALL use one clock and a synchronous active-high reset, with ports as listed below.
REQ-004 a_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 store_data  in  2  event type from GVP: 1 = data, 2 = full header, 3 = full header plus end; 0 = none.
REQ-007 store_tick  in  1  qualifies store_data for one cycle per GVP step.
REQ-008 srcs  in  32  GVP options word; bits [15:0] are the data channel mask.
REQ-009 index  in  32  GVP point index (ch0).
REQ-010 gvp_time  in  48  GVP time (ch1 = [31:0], ch2 = {16'h0, [47:32]}).
REQ-011 vec_xyzuab  in  192  X,Y,Z,U,A,B packed low-first (ch3..ch8).
REQ-012 ext_src  in  224  external signals packed low-first (ch9..ch15).
REQ-013 m_axis_tdata / m_axis_tvalid / m_axis_tready / m_axis_tlast  out/out/in/out  32/1/1/1  AXI4-Stream to DMA FIFO.
REQ-014 stall  out  1  pause request to GVP.
REQ-015 overflow  out  1  sticky, set when an event is dropped.
REQ-016 pkt_count  out  32  number of completed packets.

Function
REQ-017 An event SHALL be accepted only on a cycle with store_tick=1 and store_data!=0; it SHALL snapshot all NUM_CH channels, the type, and the mask in that cycle.
REQ-018 The mask SHALL be: type 1 uses srcs[15:0]; types 2 and 3 use 16'hFFFF.
REQ-019 Packet layout: word0 = {type[1:0], 14'h0, mask[15:0]}; then the snapshot of each set mask bit in ascending channel order; type 3 adds TRAILER_WORD as the final word.
REQ-020 m_axis_tlast SHALL be 1 on the last word of every packet only; a type-1 event with mask 0 SHALL give a single-word packet, word0 with tlast=1.
REQ-021 FSM states: IDLE, HDR, DATA, TRAILER.
REQ-022 FSM transitions: IDLE->HDR on accept or pending; HDR->DATA if mask!=0, else ->TRAILER (type 3) or ->IDLE; DATA->TRAILER/IDLE after the last set bit.
REQ-023 The FSM SHALL advance only on a handshake (tvalid && tready); tdata and tlast SHALL hold stable while tvalid=1 and tready=0.
REQ-024 Latency: an event accepted at cycle t in IDLE SHALL present word0 with tvalid=1 at t+1.
REQ-025 Under continuous tready, throughput SHALL be one word per cycle, with no bubbles between masked channels or back-to-back packets.
REQ-026 Buffering SHALL be the active snapshot plus a one-deep pending snapshot; an event arriving while busy SHALL go to pending.
REQ-027 stall SHALL equal pending-occupied (registered); the pending snapshot SHALL start in the cycle after the current tlast handshake.
REQ-028 An event arriving while pending is occupied SHALL be dropped and set overflow; the active and pending packets SHALL be unaffected.
REQ-029 An accept coincident with the final handshake of the active packet SHALL load pending, not drop.
REQ-030 pkt_count SHALL increment on each tlast handshake and wrap modulo 2^32.

Reset
REQ-031 On reset, outputs SHALL be: tvalid=0, tlast=0, tdata=0, stall=0, overflow=0, pkt_count=0; FSM=IDLE; pending cleared.
REQ-032 Reset asserted mid-packet SHALL abandon the packet; tvalid SHALL be 0 from the next cycle, with no tlast emitted.
REQ-033 Events presented during reset SHALL be ignored.

Structure
REQ-034 Shared package gvp_pkg SHALL hold: type codes (DATA=1, HDR=2, END=3), NUM_CH, the channel index map, TRAILER_WORD, and the FSM state enum.
REQ-035 One sub-module, gvp_ch_select, SHALL provide a combinational next-set-bit priority encoder over a 16-bit remaining-mask, outputting index and last flag.

Verification
REQ-036 Type-1 event, srcs=16'h0009, index=5, x=7, tready=1 -> words 32'h40000009, 5, 7 on consecutive cycles; tlast on 7; pkt_count=1.
REQ-037 Type-3 event, tready=1 -> 18 words: 32'hC000FFFF, ch0..ch15, 32'hEEEEEEEE with tlast; word0 at t+1.
REQ-038 Three type-1 events, mask 16'h00FF, on consecutive cycles with tready=0 -> stall=1 after the 2nd, overflow=1 after the 3rd; then tready=1 -> exactly two 9-word packets with the first two snapshots.
REQ-039 Random tready toggling during a type-2 packet -> tdata/tlast stable whenever stalled; words match the snapshot; no loss or duplication.
REQ-040 Reset asserted at word 4 of a 17-word type-2 packet -> tvalid=0 next cycle; pkt_count=0; the next event produces a clean word0.
REQ-041 Type-1 event with srcs[15:0]=0 -> single word 32'h40000000 with tlast=1.

Source files
------------

// File: rtl/gvp_pkg.sv
// Shared definitions for the GVP stream packer: event codes, channel map,
// FSM states and the snapshot record carried from capture to output.
package gvp_pkg;

    localparam int          DEF_NUM_CH       = 16;
    localparam logic [31:0] DEF_TRAILER_WORD = 32'hEEEEEEEE;

    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_DATA = 2'd1,
        EV_HDR  = 2'd2,
        EV_END  = 2'd3
    } gvp_ev_e;

    // Channel index map: where each GVP source lands in the packet
    localparam int CH_INDEX   = 0;
    localparam int CH_TIME_LO = 1;
    localparam int CH_TIME_HI = 2;
    localparam int CH_XYZUAB  = 3;
    localparam int NUM_XYZUAB = 6;
    localparam int CH_EXT     = 9;
    localparam int NUM_EXT    = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_DATA    = 2'd2,
        ST_TRAILER = 2'd3
    } gvp_state_e;

    typedef struct packed {
        logic [1:0]        typ;
        logic [15:0]       mask;
        logic [15:0][31:0] ch;
    } gvp_snap_t;

    function automatic logic [31:0] make_word0(input logic [1:0] typ, input logic [15:0] mask);
        return {typ, 14'h0000, mask};
    endfunction

endpackage

// File: rtl/gvp_ch_select.sv
// Next-set-bit priority encoder over the remaining channel mask; lowest
// channel wins, and last flags that it is the only bit still set.
module gvp_ch_select (
    input  logic [15:0] rem_mask,
    output logic [3:0]  idx,
    output logic        last,
    output logic        any
);

    // Scan downward so the lowest set bit is the final assignment
    always_comb begin
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (rem_mask[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        any  = (rem_mask != 16'd0);
        last = any && ((rem_mask & (rem_mask - 16'd1)) == 16'd0);
    end

endmodule

// File: rtl/gvp_stream_packer.sv
// Packs GVP store events into AXI4-Stream packets: header word, masked
// channel snapshots in ascending order, and an optional trailer word.
module gvp_stream_packer
    import gvp_pkg::*;
#(
    parameter int          NUM_CH       = DEF_NUM_CH,
    parameter logic [31:0] TRAILER_WORD = DEF_TRAILER_WORD
) (
    input  logic         a_clk,
    input  logic         reset,
    input  logic [1:0]   store_data,
    input  logic         store_tick,
    input  logic [31:0]  srcs,
    input  logic [31:0]  index,
    input  logic [47:0]  gvp_time,
    input  logic [191:0] vec_xyzuab,
    input  logic [223:0] ext_src,
    output logic [31:0]  m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         m_axis_tlast,
    output logic         stall,
    output logic         overflow,
    output logic [31:0]  pkt_count
);

    gvp_state_e        state_r, nxt_state_s;
    gvp_snap_t         in_snap_s, pend_r, start_snap_s;
    logic [15:0][31:0] raw_s;
    logic [15:0][31:0] act_ch_r;
    logic [1:0]        act_typ_r;
    logic [15:0]       rem_r, nxt_rem_s;
    logic [31:0]       tdata_r, nxt_tdata_s, pkt_count_r;
    logic              tvalid_r, nxt_tvalid_s, tlast_r, nxt_tlast_s;
    logic              pend_valid_r, overflow_r;
    logic              accept_s, busy_s, hs_s, done_s;
    logic              take_pend_s, direct_s, pend_load_s, drop_s, start_s;
    logic [3:0]        sel_idx_s;
    logic              sel_last_s, sel_any_s;
    logic              unused_s;

    assign unused_s = ^srcs[31:16];

    gvp_ch_select u_ch_select (
        .rem_mask (rem_r),
        .idx      (sel_idx_s),
        .last     (sel_last_s),
        .any      (sel_any_s)
    );

    // Map the GVP inputs onto the channel vector and form this cycle's snapshot
    always_comb begin
        raw_s             = '0;
        raw_s[CH_INDEX]   = index;
        raw_s[CH_TIME_LO] = gvp_time[31:0];
        raw_s[CH_TIME_HI] = {16'h0000, gvp_time[47:32]};
        for (int k = 0; k < NUM_XYZUAB; k++) begin
            raw_s[CH_XYZUAB + k] = vec_xyzuab[32*k +: 32];
        end
        for (int k = 0; k < NUM_EXT; k++) begin
            raw_s[CH_EXT + k] = ext_src[32*k +: 32];
        end
        in_snap_s     = '0;
        in_snap_s.typ = store_data;
        if (store_data == EV_DATA) begin
            in_snap_s.mask = srcs[15:0];
        end else begin
            in_snap_s.mask = 16'hFFFF;
        end
        for (int i = 0; i < 16; i++) begin
            if (i < NUM_CH) begin
                in_snap_s.ch[i] = raw_s[i];
            end else begin
                in_snap_s.ch[i] = 32'h0000_0000;
            end
        end
    end

    // An event lands in pending whenever it cannot start immediately; the
    // pending slot frees on the final handshake, so a coincident event is kept.
    assign accept_s     = store_tick && (store_data != 2'd0);
    assign busy_s       = (state_r != ST_IDLE);
    assign hs_s         = tvalid_r && m_axis_tready;
    assign done_s       = hs_s && tlast_r;
    assign take_pend_s  = pend_valid_r && (!busy_s || done_s);
    assign direct_s     = accept_s && !busy_s && !pend_valid_r;
    assign pend_load_s  = accept_s && !direct_s && (!pend_valid_r || take_pend_s);
    assign drop_s       = accept_s && pend_valid_r && !take_pend_s;
    assign start_s      = take_pend_s || direct_s;
    assign start_snap_s = take_pend_s ? pend_r : in_snap_s;

    // Next-state and next output word; the output register only moves on start or handshake
    always_comb begin
        nxt_state_s  = state_r;
        nxt_tdata_s  = tdata_r;
        nxt_tlast_s  = tlast_r;
        nxt_tvalid_s = tvalid_r;
        nxt_rem_s    = rem_r;
        if (start_s) begin
            nxt_state_s  = ST_HDR;
            nxt_tdata_s  = make_word0(start_snap_s.typ, start_snap_s.mask);
            nxt_tlast_s  = (start_snap_s.mask == 16'd0) && (start_snap_s.typ != EV_END);
            nxt_tvalid_s = 1'b1;
            nxt_rem_s    = start_snap_s.mask;
        end else if (hs_s) begin
            case (state_r)
                ST_HDR, ST_DATA: begin
                    if (tlast_r) begin
                        nxt_state_s  = ST_IDLE;
                        nxt_tvalid_s = 1'b0;
                        nxt_tlast_s  = 1'b0;
                    end else if (sel_any_s) begin
                        nxt_state_s = ST_DATA;
                        nxt_tdata_s = act_ch_r[sel_idx_s];
                        nxt_tlast_s = sel_last_s && (act_typ_r != EV_END);
                        nxt_rem_s   = rem_r & ~(16'd1 << sel_idx_s);
                    end else begin
                        nxt_state_s = ST_TRAILER;
                        nxt_tdata_s = TRAILER_WORD;
                        nxt_tlast_s = 1'b1;
                    end
                end
                default: begin
                    nxt_state_s  = ST_IDLE;
                    nxt_tvalid_s = 1'b0;
                    nxt_tlast_s  = 1'b0;
                end
            endcase
        end else begin
            nxt_state_s = state_r;
        end
    end

    // State, snapshot and status registers
    always_ff @(posedge a_clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            tdata_r      <= 32'h0000_0000;
            tvalid_r     <= 1'b0;
            tlast_r      <= 1'b0;
            rem_r        <= 16'd0;
            act_typ_r    <= 2'd0;
            act_ch_r     <= '0;
            pend_r       <= '0;
            pend_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
            pkt_count_r  <= 32'd0;
        end else begin
            state_r      <= nxt_state_s;
            tdata_r      <= nxt_tdata_s;
            tvalid_r     <= nxt_tvalid_s;
            tlast_r      <= nxt_tlast_s;
            rem_r        <= nxt_rem_s;
            pend_valid_r <= pend_load_s || (pend_valid_r && !take_pend_s);
            if (start_s) begin
                act_typ_r <= start_snap_s.typ;
                act_ch_r  <= start_snap_s.ch;
            end
            if (pend_load_s) begin
                pend_r <= in_snap_s;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            if (done_s) begin
                pkt_count_r <= pkt_count_r + 32'd1;
            end
        end
    end

    assign m_axis_tdata  = tdata_r;
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tlast  = tlast_r;
    assign stall         = pend_valid_r;
    assign overflow      = overflow_r;
    assign pkt_count     = pkt_count_r;

endmodule

// File: tb/tb_gvp_stream_packer.sv
// Scoreboard bench for gvp_stream_packer: directed events push expected
// words; a negedge monitor pops and compares every handshaken word.
module tb_gvp_stream_packer;

    logic         a_clk;
    logic         reset;
    logic [1:0]   store_data;
    logic         store_tick;
    logic [31:0]  srcs;
    logic [31:0]  index;
    logic [47:0]  gvp_time;
    logic [191:0] vec_xyzuab;
    logic [223:0] ext_src;
    logic [31:0]  m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic         stall;
    logic         overflow;
    logic [31:0]  pkt_count;

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [32:0]  exp_q[$];
    logic [31:0]  cv[16];

    gvp_stream_packer dut (
        .a_clk         (a_clk),
        .reset         (reset),
        .store_data    (store_data),
        .store_tick    (store_tick),
        .srcs          (srcs),
        .index         (index),
        .gvp_time      (gvp_time),
        .vec_xyzuab    (vec_xyzuab),
        .ext_src       (ext_src),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .stall         (stall),
        .overflow      (overflow),
        .pkt_count     (pkt_count)
    );

    initial begin
        a_clk = 1'b0;
        forever #5 a_clk = ~a_clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge a_clk);
        #1;
    endtask

    task automatic drive_chans();
        index    = cv[0];
        gvp_time = {cv[2][15:0], cv[1]};
        for (int k = 0; k < 6; k++) vec_xyzuab[32*k +: 32] = cv[3+k];
        for (int k = 0; k < 7; k++) ext_src[32*k +: 32] = cv[9+k];
    endtask

    task automatic set_chans(input logic [31:0] base);
        for (int i = 0; i < 16; i++) cv[i] = base + 32'(i) * 32'h0001_0003;
        cv[2] = {16'h0000, cv[2][15:0]};
        drive_chans();
    endtask

    task automatic push_pkt(input logic [31:0] word0, input logic [15:0] mask, input bit trailer);
        exp_q.push_back({(mask == 16'd0) && !trailer, word0});
        for (int i = 0; i < 16; i++) begin
            if (mask[i]) exp_q.push_back({((mask >> (i + 1)) == 16'd0) && !trailer, cv[i]});
        end
        if (trailer) exp_q.push_back({1'b1, 32'hEEEEEEEE});
    endtask

    task automatic send_event(input logic [1:0] typ, input logic [31:0] s);
        store_data = typ;
        srcs       = s;
        store_tick = 1'b1;
        tick();
        store_tick = 1'b0;
        store_data = 2'd0;
    endtask

    task automatic drain(input bit rnd, input int limit, output int cycles);
        cycles = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && cycles < limit) begin
            if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
            tick();
            cycles++;
        end
        m_axis_tready = 1'b1;
        if (cycles >= limit) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d words still expected after %0d cycles", exp_q.size(), cycles);
        end
    endtask

    // Monitor: pop-and-compare on handshakes, hold checks while back-pressured
    initial begin
        logic        prev_stalled;
        logic [31:0] prev_data;
        logic        prev_last;
        logic [32:0] e;
        prev_stalled = 1'b0;
        prev_data    = 32'h0;
        prev_last    = 1'b0;
        forever begin
            @(negedge a_clk);
            if (reset) begin
                prev_stalled = 1'b0;
            end else begin
                if (prev_stalled) begin
                    chk("hold_tvalid", 64'(m_axis_tvalid), 64'd1);
                    chk("hold_tdata", 64'(m_axis_tdata), 64'(prev_data));
                    chk("hold_tlast", 64'(m_axis_tlast), 64'(prev_last));
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL extra_word: got %h expected no word", m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word_data", 64'(m_axis_tdata), 64'(e[31:0]));
                        chk("word_last", 64'(m_axis_tlast), 64'(e[32]));
                    end
                end
                prev_stalled = m_axis_tvalid && !m_axis_tready;
                prev_data    = m_axis_tdata;
                prev_last    = m_axis_tlast;
            end
        end
    end

    initial begin
        int cyc;
        reset         = 1'b1;
        store_data    = 2'd3;
        store_tick    = 1'b1;
        srcs          = 32'h0;
        index         = 32'h0;
        gvp_time      = 48'h0;
        vec_xyzuab    = '0;
        ext_src       = '0;
        m_axis_tready = 1'b1;

        // Reset with events presented: they must be ignored
        repeat (3) tick();
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        store_tick = 1'b0;
        store_data = 2'd0;
        reset      = 1'b0;
        tick();
        chk("rst_tvalid_after", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);

        // Type-1, mask 0009, index=5, x=7
        set_chans(32'h1100_0000);
        cv[0] = 32'd5;
        cv[3] = 32'd7;
        drive_chans();
        exp_q.push_back({1'b0, 32'h40000009});
        exp_q.push_back({1'b0, 32'd5});
        exp_q.push_back({1'b1, 32'd7});
        send_event(2'd1, 32'h0000_0009);
        chk("t1_lat_tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("t1_lat_word0", 64'(m_axis_tdata), 64'h40000009);
        drain(1'b0, 100, cyc);
        chk("t1_cycles", 64'(cyc), 64'd3);
        chk("t1_pkt_count", 64'(pkt_count), 64'd1);

        // Type-1 with empty mask: single header word with tlast
        exp_q.push_back({1'b1, 32'h40000000});
        send_event(2'd1, 32'hABCD_0000);
        chk("m0_tlast", 64'(m_axis_tlast), 64'd1);
        drain(1'b0, 100, cyc);
        chk("m0_cycles", 64'(cyc), 64'd1);
        chk("m0_pkt_count", 64'(pkt_count), 64'd2);

        // Type-3: header, all 16 channels, trailer
        set_chans(32'hA500_0001);
        push_pkt(32'hC000FFFF, 16'hFFFF, 1'b1);
        send_event(2'd3, 32'h0000_0000);
        chk("t3_lat_word0", 64'(m_axis_tdata), 64'hC000FFFF);
        drain(1'b0, 200, cyc);
        chk("t3_cycles", 64'(cyc), 64'd18);
        chk("t3_pkt_count", 64'(pkt_count), 64'd3);

        // Three events under back-pressure: second pends, third drops
        m_axis_tready = 1'b0;
        set_chans(32'h2000_0010);
        push_pkt(32'h400000FF, 16'h00FF, 1'b0);
        send_event(2'd1, 32'h0000_00FF);
        set_chans(32'h3000_0020);
        push_pkt(32'h400000FF, 16'h00FF, 1'b0);
        send_event(2'd1, 32'h0000_00FF);
        chk("bp_stall_2nd", 64'(stall), 64'd1);
        chk("bp_ovf_2nd", 64'(overflow), 64'd0);
        set_chans(32'h4000_0030);
        send_event(2'd1, 32'h0000_00FF);
        chk("bp_ovf_3rd", 64'(overflow), 64'd1);
        chk("bp_stall_3rd", 64'(stall), 64'd1);
        tick();
        m_axis_tready = 1'b1;
        drain(1'b0, 200, cyc);
        chk("bp_cycles", 64'(cyc), 64'd18);
        chk("bp_pkt_count", 64'(pkt_count), 64'd5);
        chk("bp_stall_end", 64'(stall), 64'd0);
        chk("bp_ovf_sticky", 64'(overflow), 64'd1);

        // Type-2 under random tready
        set_chans(32'h5A00_0100);
        m_axis_tready = 1'b0;
        push_pkt(32'h8000FFFF, 16'hFFFF, 1'b0);
        send_event(2'd2, 32'h0000_0000);
        drain(1'b1, 400, cyc);
        chk("rnd_pkt_count", 64'(pkt_count), 64'd6);

        // Reset mid-packet at word 4 of a type-2 packet
        set_chans(32'h6600_0200);
        exp_q.push_back({1'b0, 32'h8000FFFF});
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, cv[i]});
        send_event(2'd2, 32'h0000_0000);
        repeat (4) tick();
        chk("mid_word4", 64'(m_axis_tdata), 64'(cv[3]));
        m_axis_tready = 1'b0;
        reset         = 1'b1;
        tick();
        chk("mid_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("mid_tlast", 64'(m_axis_tlast), 64'd0);
        chk("mid_pkt_count", 64'(pkt_count), 64'd0);
        chk("mid_overflow", 64'(overflow), 64'd0);
        reset         = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        chk("mid_queue_empty", 64'(exp_q.size()), 64'd0);
        set_chans(32'h7700_0300);
        cv[0] = 32'd5;
        cv[3] = 32'd7;
        drive_chans();
        exp_q.push_back({1'b0, 32'h40000009});
        exp_q.push_back({1'b0, 32'd5});
        exp_q.push_back({1'b1, 32'd7});
        send_event(2'd1, 32'h0000_0009);
        chk("post_rst_word0", 64'(m_axis_tdata), 64'h40000009);
        drain(1'b0, 100, cyc);
        chk("post_rst_pkt_count", 64'(pkt_count), 64'd1);

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
